led_display_frame_reader: RTL and testbench



---
 rtl/led_display_frame_reader.sv | 144 ++++++++++++++
 tb/tb_led_display_frame_reader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_display_frame_reader.sv
// Frame buffer feeding led_display_driver_phy: host writes pixels, rows stream out as top/bottom pairs.
// Optional double buffering with swap_ack_out is enabled by defining LED_FRAME_DOUBLE_BUFFER_EN.
module led_display_frame_reader #(
    parameter int unsigned NUM_COLS = 64,
    parameter int unsigned NUM_ROWS = 32,
    localparam int unsigned ROW_W = 6 * NUM_COLS,
    localparam int unsigned XW = $clog2(NUM_COLS),
    localparam int unsigned YW = $clog2(NUM_ROWS),
    localparam int unsigned AW = $clog2(NUM_ROWS / 2)
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             enable_in,
    input  logic             wr_en_in,
    input  logic [XW-1:0]    wr_x_in,
    input  logic [YW-1:0]    wr_y_in,
    input  logic [2:0]       wr_rgb_in,
    input  logic             swap_req_in,
    output logic [ROW_W-1:0] row_out,
    output logic             row_valid_out,
    input  logic             row_ready_in,
    output logic [AW-1:0]    row_address_out,
    output logic             frame_start_out,
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
    output logic             swap_ack_out,
`endif
    output logic [15:0]      frame_count_out
);
    localparam int unsigned HALF = NUM_ROWS / 2;
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
    localparam int unsigned IW = YW + 1;
`else
    localparam int unsigned IW = YW;
`endif
    localparam int unsigned DEPTH = 1 << IW;

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

    state_t            state, state_next;
    logic [AW-1:0]     ptr;
    logic              handshake;
    logic              last_row;
    logic [YW-1:0]     top_y, bot_y;
    logic [IW-1:0]     wr_idx, top_idx, bot_idx;
    logic [NUM_COLS-1:0] mem_r [DEPTH];
    logic [NUM_COLS-1:0] mem_g [DEPTH];
    logic [NUM_COLS-1:0] mem_b [DEPTH];

    assign handshake = (state == PRESENT) && row_ready_in;
    assign last_row  = (ptr == AW'(HALF - 1));
    assign top_y     = YW'(ptr);
    assign bot_y     = YW'(ptr) + YW'(HALF);

`ifdef LED_FRAME_DOUBLE_BUFFER_EN
    // Front bank is displayed; host writes land in the other bank.
    logic front, pending, swap_now;

    assign swap_now = pending && ((state == IDLE) || (handshake && last_row));
    assign wr_idx   = {~front, wr_y_in};
    assign top_idx  = {front, top_y};
    assign bot_idx  = {front, bot_y};

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            front        <= 1'b0;
            pending      <= 1'b0;
            swap_ack_out <= 1'b0;
        end else begin
            swap_ack_out <= swap_now;
            pending      <= swap_req_in | (pending & ~swap_now);
            if (swap_now) front <= ~front;
        end
    end
`else
    logic unused_swap_req;

    assign unused_swap_req = swap_req_in;
    assign wr_idx  = wr_y_in;
    assign top_idx = top_y;
    assign bot_idx = bot_y;
`endif

    // Pixel storage: one bit-plane per colour, one word per row.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
                mem_g[i] <= '0;
                mem_b[i] <= '0;
            end
        end else if (wr_en_in) begin
            mem_r[wr_idx][wr_x_in] <= wr_rgb_in[0];
            mem_g[wr_idx][wr_x_in] <= wr_rgb_in[1];
            mem_b[wr_idx][wr_x_in] <= wr_rgb_in[2];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable_in) state_next = FETCH;
            FETCH:   state_next = PRESENT;
            PRESENT: if (row_ready_in) state_next = enable_in ? FETCH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Row capture happens only in FETCH, so writes during PRESENT cannot disturb the held row.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            ptr             <= '0;
            row_out         <= '0;
            row_valid_out   <= 1'b0;
            row_address_out <= '0;
            frame_start_out <= 1'b0;
            frame_count_out <= '0;
        end else begin
            row_valid_out <= (state_next == PRESENT);
            case (state)
                FETCH: begin
                    row_out <= {mem_b[bot_idx], mem_g[bot_idx], mem_r[bot_idx],
                                mem_b[top_idx], mem_g[top_idx], mem_r[top_idx]};
                    row_address_out <= ptr;
                    frame_start_out <= (ptr == '0);
                end
                PRESENT: begin
                    if (handshake) begin
                        frame_start_out <= 1'b0;
                        if (last_row) frame_count_out <= frame_count_out + 16'd1;
                        if (!enable_in)    ptr <= '0;
                        else if (last_row) ptr <= '0;
                        else               ptr <= ptr + AW'(1);
                    end
                end
                default: ptr <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_led_display_frame_reader.sv
// Randomised self-checking bench for led_display_frame_reader against a row-transaction model.
module tb_led_display_frame_reader;
    localparam int unsigned NUM_COLS = 64;
    localparam int unsigned NUM_ROWS = 32;
    localparam int unsigned HALF     = NUM_ROWS / 2;
    localparam int unsigned ROW_W    = 6 * NUM_COLS;
    localparam int unsigned XW       = $clog2(NUM_COLS);
    localparam int unsigned YW       = $clog2(NUM_ROWS);
    localparam int unsigned AW       = $clog2(HALF);

    logic             clk_in = 1'b0;
    logic             reset_in, enable_in, wr_en_in, swap_req_in, row_ready_in;
    logic [XW-1:0]    wr_x_in;
    logic [YW-1:0]    wr_y_in;
    logic [2:0]       wr_rgb_in;
    logic [ROW_W-1:0] row_out;
    logic             row_valid_out, frame_start_out;
    logic [AW-1:0]    row_address_out;
    logic [15:0]      frame_count_out;
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
    logic             swap_ack_out;
`endif

    led_display_frame_reader #(.NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in),
        .wr_en_in(wr_en_in), .wr_x_in(wr_x_in), .wr_y_in(wr_y_in), .wr_rgb_in(wr_rgb_in),
        .swap_req_in(swap_req_in), .row_out(row_out), .row_valid_out(row_valid_out),
        .row_ready_in(row_ready_in), .row_address_out(row_address_out),
        .frame_start_out(frame_start_out),
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
        .swap_ack_out(swap_ack_out),
`endif
        .frame_count_out(frame_count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: pixel image plus the row transaction currently presented.
    logic [2:0] mbuf [NUM_ROWS][NUM_COLS];
    bit         m_valid = 1'b0;
    bit         m_fetch = 1'b0;
    int         m_ptr   = 0;
    int         m_count = 0;
    logic [ROW_W-1:0] m_row = '0;

    function automatic logic [ROW_W-1:0] model_row(input int r);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int c = 0; c < int'(NUM_COLS); c++)
            for (int k = 0; k < 3; k++) begin
                v[k * NUM_COLS + c]       = mbuf[r][c][k];
                v[(3 + k) * NUM_COLS + c] = mbuf[r + int'(HALF)][c][k];
            end
        return v;
    endfunction

    initial begin
        for (int r = 0; r < int'(NUM_ROWS); r++)
            for (int c = 0; c < int'(NUM_COLS); c++) mbuf[r][c] = 3'b000;
        wait (started);
        forever begin
            @(negedge clk_in);
            check("valid", ROW_W'(row_valid_out), ROW_W'(m_valid));
            check("frame_count", ROW_W'(frame_count_out), ROW_W'(m_count));
            check("frame_start", ROW_W'(frame_start_out), ROW_W'(m_valid && m_ptr == 0));
            if (m_valid) begin
                check("row_address", ROW_W'(row_address_out), ROW_W'(m_ptr));
                check("row_data", row_out, m_row);
            end
            // Advance the model with the inputs the next rising edge will sample.
            if (reset_in) begin
                m_valid = 1'b0; m_fetch = 1'b0; m_ptr = 0; m_count = 0;
                for (int r = 0; r < int'(NUM_ROWS); r++)
                    for (int c = 0; c < int'(NUM_COLS); c++) mbuf[r][c] = 3'b000;
            end else begin
                if (m_valid) begin
                    if (row_ready_in) begin
                        if (m_ptr == int'(HALF) - 1) m_count = (m_count + 1) % 65536;
                        m_valid = 1'b0;
                        if (enable_in) begin
                            m_ptr   = (m_ptr + 1) % int'(HALF);
                            m_fetch = 1'b1;
                        end else m_ptr = 0;
                    end
                end else if (m_fetch) begin
                    m_fetch = 1'b0;
                    m_valid = 1'b1;
                    m_row   = model_row(m_ptr);
                end else if (enable_in) m_fetch = 1'b1;
                if (wr_en_in) mbuf[int'(wr_y_in)][int'(wr_x_in)] = wr_rgb_in;
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_row(input int a, input int budget);
        int n;
        n = 0;
        while (!(row_valid_out === 1'b1 && row_address_out === AW'(a)) && n < budget) begin
            step();
            n++;
        end
        check($sformatf("wait_row_%0d_timeout", a), ROW_W'(n >= budget), ROW_W'(0));
    endtask

    initial begin
        logic [ROW_W-1:0] exp_row;
        reset_in = 1'b1; enable_in = 1'b0; wr_en_in = 1'b0; swap_req_in = 1'b0;
        row_ready_in = 1'b0; wr_x_in = '0; wr_y_in = '0; wr_rgb_in = '0;
        step();
        started = 1'b1;
        step();
        check("rst_valid", ROW_W'(row_valid_out), ROW_W'(0));
        check("rst_addr", ROW_W'(row_address_out), ROW_W'(0));
        check("rst_count", ROW_W'(frame_count_out), ROW_W'(0));
        check("rst_row", row_out, ROW_W'(0));

        // Empty buffer stream: latency and first frame count.
        reset_in = 1'b0; enable_in = 1'b1; row_ready_in = 1'b1;
        step();
        check("lat_n1_valid", ROW_W'(row_valid_out), ROW_W'(0));
        step();
        check("lat_n2_valid", ROW_W'(row_valid_out), ROW_W'(1));
        check("lat_n2_addr", ROW_W'(row_address_out), ROW_W'(0));
        wait_row(15, 100);
        check("count_before_wrap", ROW_W'(frame_count_out), ROW_W'(0));
        step();
        check("count_after_wrap", ROW_W'(frame_count_out), ROW_W'(1));

        // Two pixels then read back row pair 3.
        enable_in = 1'b0;
        repeat (4) step();
        check("idle_valid", ROW_W'(row_valid_out), ROW_W'(0));
        wr_en_in = 1'b1; wr_x_in = XW'(5); wr_y_in = YW'(3); wr_rgb_in = 3'b101;
        step();
        wr_x_in = XW'(63); wr_y_in = YW'(19); wr_rgb_in = 3'b010;
        step();
        wr_en_in = 1'b0; enable_in = 1'b1;
        wait_row(3, 100);
        exp_row = '0;
        exp_row[5] = 1'b1;
        exp_row[2 * NUM_COLS + 5] = 1'b1;
        exp_row[4 * NUM_COLS + 63] = 1'b1;
        check("pixel_row3", row_out, exp_row);

        // Back-pressure on row 7.
        wait_row(7, 100);
        row_ready_in = 1'b0;
        repeat (20) begin
            step();
            check("hold7_valid", ROW_W'(row_valid_out), ROW_W'(1));
            check("hold7_addr", ROW_W'(row_address_out), ROW_W'(7));
        end
        row_ready_in = 1'b1;
        step();
        check("hold7_release_gap", ROW_W'(row_valid_out), ROW_W'(0));
        step();
        check("hold7_next_valid", ROW_W'(row_valid_out), ROW_W'(1));
        check("hold7_next_addr", ROW_W'(row_address_out), ROW_W'(8));

        // Enable drops while row 4 is stalled.
        wait_row(4, 100);
        row_ready_in = 1'b0; enable_in = 1'b0;
        repeat (5) begin
            step();
            check("drop4_valid", ROW_W'(row_valid_out), ROW_W'(1));
            check("drop4_addr", ROW_W'(row_address_out), ROW_W'(4));
        end
        row_ready_in = 1'b1;
        repeat (3) begin
            step();
            check("drop4_idle", ROW_W'(row_valid_out), ROW_W'(0));
        end
        enable_in = 1'b1;
        step();
        step();
        check("reenable_valid", ROW_W'(row_valid_out), ROW_W'(1));
        check("reenable_addr", ROW_W'(row_address_out), ROW_W'(0));

        // Mid-frame reset at row 9 clears outputs and image.
        wait_row(9, 100);
        reset_in = 1'b1;
        step();
        check("midrst_valid", ROW_W'(row_valid_out), ROW_W'(0));
        check("midrst_addr", ROW_W'(row_address_out), ROW_W'(0));
        check("midrst_count", ROW_W'(frame_count_out), ROW_W'(0));
        reset_in = 1'b0;
        wait_row(3, 100);
        check("midrst_row3_clear", row_out, ROW_W'(0));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset_in     = ($urandom_range(0, 399) == 0);
            enable_in    = ($urandom_range(0, 7) != 0);
            row_ready_in = ($urandom_range(0, 3) != 0);
            wr_en_in     = $urandom_range(0, 1) == 1;
            wr_x_in      = XW'($urandom_range(0, NUM_COLS - 1));
            wr_y_in      = YW'($urandom_range(0, NUM_ROWS - 1));
            wr_rgb_in    = 3'($urandom_range(0, 7));
            swap_req_in  = ($urandom_range(0, 63) == 0);
            step();
        end
        reset_in = 1'b0; enable_in = 1'b0; wr_en_in = 1'b0; swap_req_in = 1'b0;
        row_ready_in = 1'b1;
        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
